// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates NUM_CH request channels onto the byte-serial RAM/IO bus
module mem_arbiter #(
    parameter int                NUM_CH     = 2,
    parameter int                ARB_MODE   = 1,
    parameter logic [NUM_CH-1:0] FLUSH_MASK = {NUM_CH{1'b1}},
    parameter logic [1:0]        IO_BASE_HI = 2'b11
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_enable,
    input  logic [NUM_CH-1:0]    req_valid,
    input  logic [NUM_CH-1:0]    req_rw,
    input  logic [2*NUM_CH-1:0]  req_width,
    input  logic [NUM_CH-1:0]    req_signed,
    input  logic [32*NUM_CH-1:0] req_addr,
    input  logic [32*NUM_CH-1:0] req_wdata,
    output logic [NUM_CH-1:0]    req_ready,
    output logic [NUM_CH-1:0]    rsp_valid,
    output logic [31:0]          rsp_data,
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [31:0]          mem_a,
    output logic                 mem_wr,
    input  logic                 io_buffer_full
);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_IO_WAIT, S_XFER, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d, gnt_q, gnt_d;
    logic           rw_q, rw_d, signed_q, signed_d;
    logic [2:0]     nbytes_q, nbytes_d, idx_q, idx_d;
    logic [31:0]    addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
    logic [31:0]    a_hold_q, a_comb;
    logic [7:0]     dout_hold_q, dout_comb;
    logic           wr_comb, found, abort, is_io;
    logic [PW-1:0]  pick, ci;
    logic [NUM_CH-1:0] eligible;
    logic [31:0]    wsh, ext;
    logic [1:0]     width_a [NUM_CH];
    logic [31:0]    addr_a  [NUM_CH];
    logic [31:0]    wdata_a [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign width_a[c] = req_width[2*c +: 2];
        assign addr_a[c]  = req_addr[32*c +: 32];
        assign wdata_a[c] = req_wdata[32*c +: 32];
    end

    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        case (w)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // A flush blocks masked channels from being granted in the same cycle.
    assign eligible = req_valid & ~(flush_enable ? FLUSH_MASK : '0);

    always_comb begin
        found = 1'b0;
        pick  = '0;
        ci    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ci = (ARB_MODE == 1) ? PW'((int'(ptr_q) + k) % NUM_CH) : PW'(k);
            if (!found && eligible[ci]) begin
                found = 1'b1;
                pick  = ci;
            end
        end
    end

    assign is_io = (addr_q[17:16] == IO_BASE_HI);
    assign abort = flush_enable && FLUSH_MASK[gnt_q] && !rw_q;
    assign wsh   = wdata_q >> {idx_q[1:0], 3'b000};

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        rw_d      = rw_q;
        signed_d  = signed_q;
        nbytes_d  = nbytes_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        req_ready = '0;
        rsp_valid = '0;
        a_comb    = '0;
        dout_comb = '0;
        wr_comb   = 1'b0;
        if (rdy_in && !rst_in) begin
            case (state_q)
                S_IDLE: if (found) begin
                    req_ready[pick] = 1'b1;
                    gnt_d    = pick;
                    rw_d     = req_rw[pick];
                    signed_d = req_signed[pick];
                    nbytes_d = width_bytes(width_a[pick]);
                    addr_d   = addr_a[pick];
                    wdata_d  = wdata_a[pick];
                    idx_d    = '0;
                    data_d   = '0;
                    if (ARB_MODE == 1)
                        ptr_d = (pick == PW'(NUM_CH - 1)) ? '0 : pick + PW'(1);
                    if (req_rw[pick] && addr_a[pick][17:16] == IO_BASE_HI && io_buffer_full)
                        state_d = S_IO_WAIT;
                    else
                        state_d = S_XFER;
                end
                S_IO_WAIT: if (!io_buffer_full) state_d = S_XFER;
                S_XFER: begin
                    if (idx_q < nbytes_q) begin
                        a_comb    = addr_q + 32'(idx_q);
                        dout_comb = wsh[7:0];
                    end
                    if (rw_q) begin
                        if (!(is_io && io_buffer_full)) begin
                            wr_comb = 1'b1;
                            if (idx_q == nbytes_q - 3'd1) state_d = S_DONE;
                            else                          idx_d   = idx_q + 3'd1;
                        end
                    end else begin
                        // Read bytes land one cycle behind their address.
                        for (int k = 0; k < 4; k++)
                            if (idx_q == 3'(k + 1)) data_d[8*k +: 8] = mem_din;
                        if (abort)                     state_d = S_IDLE;
                        else if (idx_q == nbytes_q)    state_d = S_DONE;
                        else                           idx_d   = idx_q + 3'd1;
                    end
                end
                S_DONE: begin
                    if (!abort) rsp_valid[gnt_q] = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (nbytes_q)
            3'd1:    ext = {{24{signed_q & data_q[7]}},  data_q[7:0]};
            3'd2:    ext = {{16{signed_q & data_q[15]}}, data_q[15:0]};
            default: ext = data_q;
        endcase
    end

    // While frozen, the bus shows the last active address so the in-flight byte is re-read on resume.
    assign mem_a    = rst_in ? '0 : (rdy_in ? a_comb : a_hold_q);
    assign mem_dout = rst_in ? '0 : (rdy_in ? dout_comb : dout_hold_q);
    assign mem_wr   = wr_comb;
    assign rsp_data = (!rst_in && state_q == S_DONE && !rw_q) ? ext : '0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            rw_q        <= 1'b0;
            signed_q    <= 1'b0;
            nbytes_q    <= 3'd1;
            idx_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            a_hold_q    <= '0;
            dout_hold_q <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            rw_q        <= rw_d;
            signed_q    <= signed_d;
            nbytes_q    <= nbytes_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
            a_hold_q    <= a_comb;
            dout_hold_q <= dout_comb;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int NCH = 2;

    logic clk = 1'b0, rst = 1'b0, rdy = 1'b1, flush = 1'b0, io_full = 1'b0;
    logic [NCH-1:0]    req_valid = '0, req_rw = '0, req_signed = '0;
    logic [2*NCH-1:0]  req_width = '0;
    logic [32*NCH-1:0] req_addr = '0, req_wdata = '0;
    logic [NCH-1:0]    req_ready, rsp_valid, ready_fx, rsp_valid_fx;
    logic [31:0]       rsp_data, mem_a, rsp_data_fx, mem_a_fx;
    logic [7:0]        mem_din = '0, mem_din_fx = '0, mem_dout, mem_dout_fx;
    logic              mem_wr, mem_wr_fx;

    mem_arbiter #(.NUM_CH(NCH), .ARB_MODE(1)) u_rr (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_enable(flush),
        .req_valid(req_valid), .req_rw(req_rw), .req_width(req_width), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_full));

    mem_arbiter #(.NUM_CH(NCH), .ARB_MODE(0)) u_fx (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_enable(flush),
        .req_valid(req_valid), .req_rw(req_rw), .req_width(req_width), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_fx), .rsp_valid(rsp_valid_fx),
        .rsp_data(rsp_data_fx), .mem_din(mem_din_fx), .mem_dout(mem_dout_fx), .mem_a(mem_a_fx),
        .mem_wr(mem_wr_fx), .io_buffer_full(io_full));

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    int last_t0 = 0, last_trsp = 0;
    logic [31:0] tr_a[$];
    logic        tr_w[$];
    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5a;
    endfunction
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Bus memory: read data follows the previous cycle's address.
    always @(posedge clk) begin
        mem_din    <= ram_rd(mem_a);
        mem_din_fx <= ram_rd(mem_a_fx);
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    function automatic int rr_pick(input logic [NCH-1:0] m, input int p);
        for (int k = 0; k < NCH; k++) if (m[(p + k) % NCH]) return (p + k) % NCH;
        return -1;
    endfunction

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] expect_read(input logic [31:0] a, input logic [1:0] w, input bit sg);
        int n = nbytes(w);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_rd(a + 32'(i))) << (8 * i));
        if (sg && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        ram[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_txn(input int ch, input bit rw, input logic [1:0] w, input bit sg,
                          input logic [31:0] addr, input logic [31:0] wd, input int flush_at,
                          input int rdy_at, input int full_cyc, input bit expect_rsp,
                          output logic [31:0] data, output int lat, output int nwr);
        int t0, k, budget;
        bit got;
        tr_a.delete(); tr_w.delete();
        nwr = 0; lat = -1; data = '0; got = 1'b0; budget = 0; t0 = 0;
        @(posedge clk); #1;
        if (full_cyc > 0) io_full = 1'b1;
        req_valid[ch] = 1'b1; req_rw[ch] = rw; req_width[2*ch +: 2] = w; req_signed[ch] = sg;
        req_addr[32*ch +: 32] = addr; req_wdata[32*ch +: 32] = wd;
        while (1) begin
            @(negedge clk);
            if (req_ready[ch]) begin got = 1'b1; break; end
            budget++;
            if (budget >= 50) break;
            @(posedge clk); #1;
        end
        t0 = cyc; last_t0 = t0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL grant_timeout ch=%0d got=no_req_ready expected=req_ready", ch);
            req_valid[ch] = 1'b0;
        end
        k = 0;
        while (got && k < (expect_rsp ? 40 : 12)) begin
            @(posedge clk); #1;
            k = cyc - t0;
            if (k == 1) req_valid[ch] = 1'b0;
            flush = (k == flush_at);
            rdy = !(rdy_at > 0 && k >= rdy_at && k < rdy_at + 3);
            if (full_cyc > 0 && k >= full_cyc) io_full = 1'b0;
            @(negedge clk);
            tr_a.push_back(mem_a); tr_w.push_back(mem_wr);
            nwr += int'(mem_wr);
            if (rsp_valid[ch]) begin data = rsp_data; lat = k; last_trsp = cyc; break; end
        end
        flush = 1'b0; rdy = 1'b1; io_full = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b expected=00", req_ready); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; req_valid = '0;
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || mem_wr !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b/%b/%b expected=0", req_ready, rsp_valid, mem_wr);
        end
        checks++;
        if (mem_a !== '0 || mem_dout !== '0 || rsp_data !== '0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%h expected=0", mem_a, mem_dout, rsp_data);
        end
    endtask

    task automatic test_read_basic();
        logic [31:0] d; int lat, nwr; bit seq_ok;
        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
        do_txn(0, 0, 2'd2, 0, 32'h100, 0, -1, -1, 0, 1, d, lat, nwr);
        checks++;
        if (lat != 6) begin failures++; $display("FAIL read4_latency got=%0d expected=6", lat); end
        checks++;
        if (d !== 32'h44332211) begin failures++; $display("FAIL read4_data got=%h expected=44332211", d); end
        seq_ok = (tr_a.size() >= 4);
        for (int i = 0; i < 4 && seq_ok; i++) if (tr_a[i] !== 32'h100 + 32'(i)) seq_ok = 1'b0;
        checks++;
        if (!seq_ok || nwr != 0) begin failures++; $display("FAIL read4_addr_seq got=%p wr=%0d expected=100..103", tr_a, nwr); end
    endtask

    task automatic test_sign();
        logic [31:0] d; int lat, nwr;
        poke(32'h200, 8'h80); poke(32'h210, 8'h34); poke(32'h211, 8'h92);
        do_txn(1, 0, 2'd0, 1, 32'h200, 0, -1, -1, 0, 1, d, lat, nwr);
        checks++;
        if (d !== 32'hFFFFFF80 || lat != 3) begin failures++; $display("FAIL sign_1b got=%h lat=%0d expected=ffffff80 lat=3", d, lat); end
        do_txn(1, 0, 2'd0, 0, 32'h200, 0, -1, -1, 0, 1, d, lat, nwr);
        checks++;
        if (d !== 32'h00000080) begin failures++; $display("FAIL zext_1b got=%h expected=00000080", d); end
        do_txn(1, 0, 2'd1, 1, 32'h210, 0, -1, -1, 0, 1, d, lat, nwr);
        checks++;
        if (d !== 32'hFFFF9234 || lat != 4) begin failures++; $display("FAIL sign_2b got=%h lat=%0d expected=ffff9234 lat=4", d, lat); end
    endtask

    task automatic test_arbitration();
        int exp_ptr, n_rr, n_fx, g, gprev;
        logic [NCH-1:0] expv, m;
        do_reset();
        exp_ptr = 0; n_rr = 0; n_fx = 0;
        req_rw = '0; req_width = '0; req_signed = '0;
        req_addr = {32'h2000, 32'h1000};
        req_valid = '1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (req_ready !== '0) begin
                g = rr_pick(req_valid, exp_ptr);
                expv = NCH'(1) << g;
                n_rr++; checks++;
                if (req_ready !== expv) begin failures++; $display("FAIL rr_grant got=%b expected=%b", req_ready, expv); end
                exp_ptr = (g + 1) % NCH;
            end
            if (ready_fx !== '0) begin
                n_fx++; checks++;
                if (ready_fx !== 2'b01) begin failures++; $display("FAIL fixed_grant got=%b expected=01", ready_fx); end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (n_rr != 10 || n_fx != 10) begin failures++; $display("FAIL grant_count got=%0d/%0d expected=10/10", n_rr, n_fx); end
        req_valid = '0;
        repeat (8) @(posedge clk);
        #1;
        gprev = -1;
        for (int c = 0; c < 120; c++) begin
            if (gprev >= 0) req_valid[gprev] = 1'b0;
            gprev = -1;
            for (int ch = 0; ch < NCH; ch++) begin
                if (!req_valid[ch] && $urandom_range(0, 2) == 0) begin
                    req_valid[ch] = 1'b1;
                    req_width[2*ch +: 2] = 2'($urandom_range(0, 3));
                    req_addr[32*ch +: 32] = $urandom_range(0, 16'hFFFF);
                end
            end
            @(negedge clk);
            if (req_ready !== '0) begin
                m = req_valid;
                g = rr_pick(m, exp_ptr);
                expv = (g >= 0) ? (NCH'(1) << g) : '0;
                checks++;
                if (req_ready !== expv) begin failures++; $display("FAIL rr_random got=%b expected=%b mask=%b", req_ready, expv, m); end
                for (int ch = 0; ch < NCH; ch++) if (req_ready[ch]) gprev = ch;
                exp_ptr = (gprev + 1) % NCH;
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_io_stall();
        logic [31:0] d; int lat, nwr; bit early;
        do_txn(1, 1, 2'd0, 0, 32'h30000, 32'h41, -1, -1, 5, 1, d, lat, nwr);
        ref_mem[32'h30000] = 8'h41;
        checks++;
        if (lat != 7) begin failures++; $display("FAIL io_stall_latency got=%0d expected=7", lat); end
        early = 1'b0;
        for (int i = 0; i < 5 && i < tr_w.size(); i++) if (tr_w[i]) early = 1'b1;
        checks++;
        if (early || nwr != 1) begin failures++; $display("FAIL io_stall_wr got=early%0d/n%0d expected=early0/n1", early, nwr); end
        checks++;
        if (ram_rd(32'h30000) !== 8'h41) begin failures++; $display("FAIL io_stall_byte got=%h expected=41", ram_rd(32'h30000)); end
    endtask

    task automatic test_flush();
        logic [31:0] d; int lat, nwr; logic [31:0] a4;
        do_txn(0, 0, 2'd2, 0, 32'h400, 0, 3, -1, 0, 0, d, lat, nwr);
        a4 = (tr_a.size() > 3) ? tr_a[3] : 32'hDEAD;
        checks++;
        if (lat != -1) begin failures++; $display("FAIL flush_read_rsp got=lat%0d expected=no_rsp", lat); end
        checks++;
        if (a4 !== '0) begin failures++; $display("FAIL flush_idle_addr got=%h expected=0", a4); end
        do_txn(0, 1, 2'd2, 0, 32'h500, 32'hCAFEBABE, 3, -1, 0, 1, d, lat, nwr);
        for (int i = 0; i < 4; i++) ref_mem[32'h500 + 32'(i)] = 8'(32'hCAFEBABE >> (8 * i));
        checks++;
        if (lat != 5 || nwr != 4) begin failures++; $display("FAIL flush_write got=lat%0d/n%0d expected=lat5/n4", lat, nwr); end
        do_txn(0, 0, 2'd2, 0, 32'h500, 0, -1, -1, 0, 1, d, lat, nwr);
        checks++;
        if (d !== 32'hCAFEBABE) begin failures++; $display("FAIL flush_write_data got=%h expected=cafebabe", d); end
    endtask

    task automatic test_rdy_freeze();
        logic [31:0] d; int lat, nwr; bit held;
        poke(32'h600, 8'hC3); poke(32'h601, 8'h7E);
        do_txn(0, 0, 2'd1, 0, 32'h600, 0, -1, 2, 0, 1, d, lat, nwr);
        checks++;
        if (lat != 7 || d !== 32'h00007EC3) begin failures++; $display("FAIL freeze_read got=%h lat=%0d expected=00007ec3 lat=7", d, lat); end
        held = (tr_a.size() >= 4);
        for (int i = 1; i < 4 && held; i++) if (tr_a[i] !== tr_a[0]) held = 1'b0;
        checks++;
        if (!held || nwr != 0) begin failures++; $display("FAIL freeze_hold got=%p wr=%0d expected=addr_held wr0", tr_a, nwr); end
    endtask

    task automatic test_random();
        logic [31:0] d, addr, wd, e; int lat, nwr, n, ch, prev_rsp; bit rw, sg, ok; logic [1:0] w;
        prev_rsp = -100;
        for (int it = 0; it < 40; it++) begin
            ch = $urandom_range(0, NCH - 1); rw = 1'($urandom_range(0, 1));
            w = 2'($urandom_range(0, 3)); sg = 1'($urandom_range(0, 1));
            addr = $urandom_range(0, 16'hFFFF); wd = $urandom;
            if (it % 8 == 7) begin rw = 1'b0; addr = 32'hFFFF_FFFE; end
            n = nbytes(w);
            e = expect_read(addr, w, sg);
            do_txn(ch, rw, w, sg, addr, wd, -1, -1, 0, 1, d, lat, nwr);
            if (rw) for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = 8'(wd >> (8 * i));
            checks++;
            if (lat != (rw ? n + 1 : n + 2)) begin failures++; $display("FAIL rand_latency it=%0d got=%0d expected=%0d", it, lat, rw ? n + 1 : n + 2); end
            checks++;
            if (!rw && d !== e) begin failures++; $display("FAIL rand_data it=%0d got=%h expected=%h", it, d, e); end
            if (rw && nwr != n) begin failures++; $display("FAIL rand_wr_count it=%0d got=%0d expected=%0d", it, nwr, n); end
            ok = (tr_a.size() >= n);
            for (int i = 0; i < n && ok; i++) if (tr_a[i] !== addr + 32'(i)) ok = 1'b0;
            checks++;
            if (!ok) begin failures++; $display("FAIL rand_addr_seq it=%0d got=%p base=%h", it, tr_a, addr); end
            if (it > 0) begin
                checks++;
                if (last_t0 - prev_rsp != 1) begin failures++; $display("FAIL back_to_back it=%0d got=gap%0d expected=gap1", it, last_t0 - prev_rsp); end
            end
            prev_rsp = last_trsp;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        test_reset();
        test_read_basic();
        test_sign();
        test_arbitration();
        test_io_stall();
        test_flush();
        test_rdy_freeze();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
